ripple_add_seq: RTL

RIPPLE_ADD_SEQ -- requirements
Module: ripple_add_seq

---
 rtl/ripple_add_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ripple_add_seq.sv
// Multi-byte adder that reuses one 8-bit ripple slice per byte, LSB byte first.
// Define RIPPLE_ADD_SEQ_SUB_MODE_EN to add the sub port (a + ~b + 1 when sub=1).
module ripple_add_seq #(
    parameter int NBYTES = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [8*NBYTES-1:0] a,
    input  logic [8*NBYTES-1:0] b,
    input  logic                cin,
`ifdef RIPPLE_ADD_SEQ_SUB_MODE_EN
    input  logic                sub,
`endif
    output logic                busy,
    output logic                done,
    output logic [8*NBYTES-1:0] sum,
    output logic                cout
);

    localparam int W  = 8 * NBYTES;
    localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic [W-1:0]    acc_q;
    logic [W-1:0]    sum_q;
    logic [IW-1:0]   idx_q;
    logic            carry_q;
    logic            cout_q;
    logic            busy_q;
    logic            done_q;

    logic [W-1:0]    b_load;
    logic            carry_load;
    logic [7:0]      a_byte;
    logic [7:0]      b_byte;
    logic [7:0]      slice_sum_d;
    logic            slice_cout_d;
    logic [W-1:0]    acc_d;
    logic            last_byte;

    // Subtraction is folded in at load time: B is stored inverted and carry starts at 1.
`ifdef RIPPLE_ADD_SEQ_SUB_MODE_EN
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    always_comb begin
        a_byte = a_q[{idx_q, 3'b000} +: 8];
        b_byte = b_q[{idx_q, 3'b000} +: 8];
        {slice_cout_d, slice_sum_d} = {1'b0, a_byte} + {1'b0, b_byte} + {8'd0, carry_q};
        acc_d = acc_q;
        acc_d[{idx_q, 3'b000} +: 8] = slice_sum_d;
    end

    assign last_byte = (idx_q == IW'(NBYTES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b_load;
                        carry_q <= carry_load;
                        idx_q   <= '0;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end else begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= slice_cout_d;
                    idx_q   <= idx_q + IW'(1);
                    // Outputs change only here, so partial sums never leak out.
                    if (last_byte) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        sum_q   <= acc_d;
                        cout_q  <= slice_cout_d;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule
